// File: rtl/jpeg_frame_sequencer.sv
// jpeg_frame_sequencer
//   Frame-level controller for the jpeg_top encoder core. Walks a frame held in
//   external pixel memory as 8x8 blocks in block-raster order, streams every
//   block's 64 pixels into the encoder, then captures the encoder's 32-bit
//   bitstream words (including the final partial word) for a downstream sink.
//
// Ports
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   start                        one-cycle frame request, accepted only when idle
//   base_addr/line_stride        frame origin and memory line pitch (sampled on start)
//   blocks_x/blocks_y            frame size in 8x8 blocks (sampled on start)
//   mem_rd/mem_addr/mem_data     pixel memory read port, data returns one cycle later
//   enc_en/enc_dati/enc_eof      encoder pixel stream
//   enc_bits/enc_rdy/enc_eof_cnt/enc_eof_p   encoder bitstream strobes
//   out_word/out_valid/out_last/out_nbits    captured bitstream to the sink
//   busy/done/error/word_count   frame status
module jpeg_frame_sequencer #(
  parameter int ADDR_W        = 24,
  parameter int GAP           = 0,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       line_stride,
  input  logic [7:0]        blocks_x,
  input  logic [7:0]        blocks_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_data,
  output logic              enc_en,
  output logic [23:0]       enc_dati,
  output logic              enc_eof,
  input  logic [31:0]       enc_bits,
  input  logic              enc_rdy,
  input  logic [4:0]        enc_eof_cnt,
  input  logic              enc_eof_p,
  output logic [31:0]       out_word,
  output logic              out_valid,
  output logic              out_last,
  output logic [5:0]        out_nbits,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [23:0]       word_count
);

  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) + 1 : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, row_base_q, blk_base_q, rowblk_base_q;
  logic [15:0]       stride_q;
  logic [7:0]        bx_last_q, by_last_q, bx_q, by_q;
  logic [2:0]        col_q, row_q;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              en_q, eof_q;
  logic [31:0]       out_word_q;
  logic              out_valid_q, out_last_q;
  logic [5:0]        out_nbits_q;
  logic              err_q, eof_seen_q;
  logic [23:0]       wcnt_q;

  logic              start_acc, last_col, last_row, blk_end, at_last_bx, last_blk;
  logic              drain_timeout, cap_rdy, cap_eof;
  logic [ADDR_W-1:0] stride_ext, stride8, next_blk, next_rowblk;

  assign start_acc   = (state_q == S_IDLE) && start;
  assign last_col    = (col_q == 3'd7);
  assign last_row    = (row_q == 3'd7);
  assign blk_end     = last_col && last_row;
  assign at_last_bx  = (bx_q == bx_last_q);
  assign last_blk    = at_last_bx && (by_q == by_last_q);
  assign stride_ext  = ADDR_W'(stride_q);
  assign stride8     = ADDR_W'({stride_q, 3'b000});
  assign next_blk    = blk_base_q + ADDR_W'(8);
  assign next_rowblk = rowblk_base_q + stride8;

  // An end-of-frame word seen earlier (e.g. while the last block still streams)
  // also releases DRAIN, so a fast encoder cannot cause a false timeout.
  assign drain_timeout = (state_q == S_DRAIN) && !enc_eof_p && !eof_seen_q &&
                         (drain_cnt_q == DRAIN_LAST);

  assign cap_rdy = busy && enc_rdy;
  assign cap_eof = busy && enc_eof_p;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = '0;
    drain_cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (blocks_x == 8'd0 || blocks_y == 8'd0) state_d = S_DONE;
          else                                      state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (blk_end) begin
          if (last_blk) begin
            state_d     = S_DRAIN;
            // counts cycles since the last pixel read
            drain_cnt_d = DW'(1);
          end else if (GAP > 0) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_FETCH;
          gap_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DW'(1);
        if (enc_eof_p || eof_seen_q || drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_rd = (state_q == S_FETCH);
    busy   = (state_q == S_FETCH) || (state_q == S_GAP) || (state_q == S_DRAIN);
    done   = (state_q == S_DONE);
  end

  assign mem_addr   = mem_rd ? addr_q : '0;
  assign enc_en     = en_q;
  assign enc_dati   = en_q ? mem_data : 24'd0;
  assign enc_eof    = eof_q;
  assign out_word   = out_word_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_nbits  = out_nbits_q;
  assign error      = err_q;
  assign word_count = wcnt_q;

  // Address walk: running bases per row, per block and per block row; no multiplies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q        <= '0;
      row_base_q    <= '0;
      blk_base_q    <= '0;
      rowblk_base_q <= '0;
      stride_q      <= '0;
      bx_last_q     <= '0;
      by_last_q     <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      en_q          <= 1'b0;
      eof_q         <= 1'b0;
    end else begin
      // pixel data returns one cycle after the read, so the encoder strobes trail it
      en_q  <= (state_q == S_FETCH);
      eof_q <= (state_q == S_FETCH) && (row_q == 3'd0) && (col_q == 3'd0) && last_blk;
      if (start_acc) begin
        addr_q        <= base_addr;
        row_base_q    <= base_addr;
        blk_base_q    <= base_addr;
        rowblk_base_q <= base_addr;
        stride_q      <= line_stride;
        bx_last_q     <= blocks_x - 8'd1;
        by_last_q     <= blocks_y - 8'd1;
        bx_q          <= '0;
        by_q          <= '0;
        col_q         <= '0;
        row_q         <= '0;
      end else if (state_q == S_FETCH) begin
        if (!last_col) begin
          col_q  <= col_q + 3'd1;
          addr_q <= addr_q + ADDR_W'(1);
        end else if (!last_row) begin
          col_q      <= '0;
          row_q      <= row_q + 3'd1;
          row_base_q <= row_base_q + stride_ext;
          addr_q     <= row_base_q + stride_ext;
        end else begin
          col_q <= '0;
          row_q <= '0;
          if (!at_last_bx) begin
            bx_q       <= bx_q + 8'd1;
            blk_base_q <= next_blk;
            row_base_q <= next_blk;
            addr_q     <= next_blk;
          end else begin
            bx_q          <= '0;
            by_q          <= by_q + 8'd1;
            rowblk_base_q <= next_rowblk;
            blk_base_q    <= next_rowblk;
            row_base_q    <= next_rowblk;
            addr_q        <= next_rowblk;
          end
        end
      end
    end
  end

  // Bitstream capture and frame status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_nbits_q <= '0;
      err_q       <= 1'b0;
      eof_seen_q  <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      out_valid_q <= cap_rdy || cap_eof;
      out_last_q  <= cap_eof;
      // the final partial word wins over a simultaneous full word
      if (cap_rdy || cap_eof) begin
        out_word_q  <= enc_bits;
        out_nbits_q <= cap_eof ? {1'b0, enc_eof_cnt} : 6'd32;
      end
      if (start_acc)                      wcnt_q <= '0;
      else if (cap_rdy || cap_eof)        wcnt_q <= wcnt_q + 24'd1;
      if (start_acc)                      err_q <= 1'b0;
      else if (drain_timeout || (cap_rdy && cap_eof)) err_q <= 1'b1;
      if (start_acc)                      eof_seen_q <= 1'b0;
      else if (cap_eof)                   eof_seen_q <= 1'b1;
    end
  end

endmodule
